// File: rtl/shift_seq_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_unit_pkg
// Description : Shared operation and FSM state encodings for the iterative
//               shift/rotate engine.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_seq_unit_pkg;

    typedef enum logic [1:0] {
        SH_SRL = 2'b00,
        SH_SLL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } sh_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } sh_state_t;

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Combinational single-step shifter, moves acc by k bits.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import shift_seq_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]   acc,
    input  logic [SHAMT_W-1:0] k,
    input  sh_op_t             op,
    input  logic               sign,
    output logic [WIDTH-1:0]   shifted
);

    localparam logic [WIDTH-1:0] c_ones = '1;

    // Vacated upper bits for arithmetic shift; the sign is the one captured at start.
    logic [WIDTH-1:0] w_hi_mask;
    assign w_hi_mask = ~(c_ones >> k);

    always_comb begin
        shifted = acc >> k;
        case (op)
            SH_SRL:  shifted = acc >> k;
            SH_SLL:  shifted = acc << k;
            SH_SRA:  shifted = (acc >> k) | (sign ? w_hi_mask : '0);
            SH_ROR:  shifted = (acc >> k) | (acc << (WIDTH - int'(k)));
            default: shifted = acc >> k;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_unit
// Description : Multi-cycle shift/rotate engine, STEP bits per cycle, with a
//               start/busy/done handshake and flush abort.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_unit
    import shift_seq_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] num,
    input  logic [WIDTH-1:0]   din,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dout
);

    localparam logic [SHAMT_W-1:0] c_step = SHAMT_W'(STEP);

    sh_state_t          r_state;
    sh_state_t          w_next;
    sh_op_t             r_op;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_dout;
    logic [SHAMT_W-1:0] r_rem;
    logic               r_sign;
    logic               w_accept;
    logic               w_last;
    logic [SHAMT_W-1:0] w_k;
    logic [WIDTH-1:0]   w_shifted;

    // The final step consumes whatever is left, so rem lands exactly on zero.
    assign w_last = (r_rem <= c_step);
    assign w_k    = w_last ? r_rem : c_step;

    shift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .acc     (r_acc),
        .k       (w_k),
        .op      (r_op),
        .sign    (r_sign),
        .shifted (w_shifted)
    );

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_accept = 1'b1;
                        w_next   = (num == '0) ? S_DONE : S_RUN;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
                S_RUN:   w_next = w_last ? S_DONE : S_RUN;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= SH_SRL;
            r_acc   <= '0;
            r_rem   <= '0;
            r_sign  <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_next;
            if (!flush) begin
                if (w_accept) begin
                    if (num == '0) begin
                        r_dout <= din;
                    end else begin
                        r_acc  <= din;
                        r_rem  <= num;
                        r_op   <= sh_op_t'(op);
                        r_sign <= din[WIDTH-1];
                    end
                end else if (r_state == S_RUN) begin
                    r_acc <= w_shifted;
                    r_rem <= r_rem - w_k;
                    if (w_last) begin
                        r_dout <= w_shifted;
                    end
                end
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign dout = r_dout;

endmodule
`default_nettype wire
